// File: rtl/snake_tick_ctrl_if.sv
// +----------------------------------------------------------------------+
// | snake_tick_ctrl_if: link between the game sequencer and body block.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface snake_tick_ctrl_if;
    logic [7:0] head_1_x;
    logic [7:0] head_2_x;
    logic [6:0] head_1_y;
    logic [6:0] head_2_y;
    logic [5:0] seg_idx;
    logic [7:0] seg_1_x;
    logic [7:0] seg_2_x;
    logic [6:0] seg_1_y;
    logic [6:0] seg_2_y;
    logic [7:0] food_x;
    logic [6:0] food_y;
    logic       respawned_1;
    logic       respawned_2;
    logic       go_signal;
    logic [1:0] dir_1;
    logic [1:0] dir_2;
    logic [5:0] snake_1_size;
    logic [5:0] snake_2_size;
    logic       respawn_1;
    logic       respawn_2;
    logic [1:0] food_eaten;
    logic [1:0] dead;

    modport master (
        input  head_1_x, head_2_x, head_1_y, head_2_y,
        input  seg_1_x, seg_2_x, seg_1_y, seg_2_y,
        input  food_x, food_y, respawned_1, respawned_2,
        output seg_idx, go_signal, dir_1, dir_2,
        output snake_1_size, snake_2_size, respawn_1, respawn_2,
        output food_eaten, dead
    );

    modport slave (
        output head_1_x, head_2_x, head_1_y, head_2_y,
        output seg_1_x, seg_2_x, seg_1_y, seg_2_y,
        output food_x, food_y, respawned_1, respawned_2,
        input  seg_idx, go_signal, dir_1, dir_2,
        input  snake_1_size, snake_2_size, respawn_1, respawn_2,
        input  food_eaten, dead
    );
endinterface

`default_nettype wire

// File: rtl/snake_tick_ctrl.sv
// +----------------------------------------------------------------------+
// | snake_tick_ctrl: two-snake game-step sequencer, direction filter,    |
// | collision/food scan and respawn handshake. Optional macro: PAUSE_EN. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module snake_tick_ctrl #(
    parameter int TICK_DIV = 2500000,
    parameter int GRID_W   = 160,
    parameter int GRID_H   = 120,
    parameter int INIT_LEN = 5,
    parameter int MAX_LEN  = 63
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] in_dir_1,
    input  wire logic [1:0] in_dir_2,
`ifdef PAUSE_EN
    input  wire logic       pause,
`endif
    snake_tick_ctrl_if.master bus
);

    localparam int              CW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   C_TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [5:0]      C_INIT_LEN  = 6'(INIT_LEN);
    localparam logic [5:0]      C_MAX_LEN   = 6'(MAX_LEN);
    localparam logic [5:0]      C_LAST_IDX  = 6'(MAX_LEN - 1);
    localparam logic [8:0]      C_GRID_W    = 9'(GRID_W);
    localparam logic [7:0]      C_GRID_H    = 8'(GRID_H);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MOVE       = 3'd1,
        S_CHECK_HEAD = 3'd2,
        S_SCAN       = 3'd3,
        S_RESOLVE    = 3'd4,
        S_RESPAWN    = 3'd5
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_tick;
    logic          r_go;
    logic [1:0]    r_dir_1;
    logic [1:0]    r_dir_2;
    logic [5:0]    r_size_1;
    logic [5:0]    r_size_2;
    logic [5:0]    r_seg_idx;
    logic          r_respawn_1;
    logic          r_respawn_2;
    logic [1:0]    r_food;
    logic [1:0]    r_dead;
    logic [1:0]    r_kill;

    logic          w_run;
    logic          w_wall_1;
    logic          w_wall_2;
    logic          w_h2h;
    logic [1:0]    w_kill_head;
    logic          w_food_1;
    logic          w_food_2;
    logic          w_live_1;
    logic          w_live_2;
    logic [1:0]    w_scan_kill;
    logic [1:0]    w_kill_all;
    logic          w_pend_1;
    logic          w_pend_2;

`ifdef PAUSE_EN
    assign w_run = ~pause;
`else
    assign w_run = 1'b1;
`endif

    // A move off the low edge wraps to a large coordinate, so one >= test covers both walls.
    assign w_wall_1    = ({1'b0, bus.head_1_x} >= C_GRID_W) || ({1'b0, bus.head_1_y} >= C_GRID_H);
    assign w_wall_2    = ({1'b0, bus.head_2_x} >= C_GRID_W) || ({1'b0, bus.head_2_y} >= C_GRID_H);
    assign w_h2h       = (bus.head_1_x == bus.head_2_x) && (bus.head_1_y == bus.head_2_y);
    assign w_kill_head = {w_wall_2 | w_h2h, w_wall_1 | w_h2h};
    assign w_food_1    = (bus.head_1_x == bus.food_x) && (bus.head_1_y == bus.food_y);
    assign w_food_2    = (bus.head_2_x == bus.food_x) && (bus.head_2_y == bus.food_y);

    assign w_live_1       = r_seg_idx < r_size_1;
    assign w_live_2       = r_seg_idx < r_size_2;
    assign w_scan_kill[0] = (w_live_1 && bus.head_1_x == bus.seg_1_x && bus.head_1_y == bus.seg_1_y)
                         || (w_live_2 && bus.head_1_x == bus.seg_2_x && bus.head_1_y == bus.seg_2_y);
    assign w_scan_kill[1] = (w_live_1 && bus.head_2_x == bus.seg_1_x && bus.head_2_y == bus.seg_1_y)
                         || (w_live_2 && bus.head_2_x == bus.seg_2_x && bus.head_2_y == bus.seg_2_y);
    assign w_kill_all     = r_kill | w_scan_kill;

    assign w_pend_1 = r_respawn_1 & ~bus.respawned_1;
    assign w_pend_2 = r_respawn_2 & ~bus.respawned_2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_go        <= 1'b0;
            r_dir_1     <= 2'd3;
            r_dir_2     <= 2'd1;
            r_size_1    <= C_INIT_LEN;
            r_size_2    <= C_INIT_LEN;
            r_seg_idx   <= 6'd0;
            r_respawn_1 <= 1'b0;
            r_respawn_2 <= 1'b0;
            r_food      <= 2'b00;
            r_dead      <= 2'b00;
            r_kill      <= 2'b00;
        end else begin
            r_go   <= 1'b0;
            r_food <= 2'b00;
            r_dead <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    // Only a perpendicular turn changes heading; reversals and repeats are dropped.
                    if (in_dir_1[0] != r_dir_1[0]) r_dir_1 <= in_dir_1;
                    if (in_dir_2[0] != r_dir_2[0]) r_dir_2 <= in_dir_2;
                    if (w_run) begin
                        if (r_tick == C_TICK_LAST) begin
                            r_tick  <= '0;
                            r_go    <= 1'b1;
                            r_state <= S_MOVE;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                S_MOVE: r_state <= S_CHECK_HEAD;
                S_CHECK_HEAD: begin
                    r_kill <= w_kill_head;
                    if (w_food_1 && !w_kill_head[0]) begin
                        r_food[0] <= 1'b1;
                        if (r_size_1 < C_MAX_LEN) r_size_1 <= r_size_1 + 6'd1;
                    end
                    if (w_food_2 && !w_kill_head[1]) begin
                        r_food[1] <= 1'b1;
                        if (r_size_2 < C_MAX_LEN) r_size_2 <= r_size_2 + 6'd1;
                    end
                    r_seg_idx <= 6'd1;
                    r_state   <= S_SCAN;
                end
                S_SCAN: begin
                    r_kill <= w_kill_all;
                    if (r_seg_idx == C_LAST_IDX) begin
                        r_seg_idx <= 6'd0;
                        r_dead    <= w_kill_all;
                        r_state   <= S_RESOLVE;
                    end else begin
                        r_seg_idx <= r_seg_idx + 6'd1;
                    end
                end
                S_RESOLVE: begin
                    r_kill <= 2'b00;
                    if (|r_kill) begin
                        r_respawn_1 <= r_kill[0];
                        r_respawn_2 <= r_kill[1];
                        r_state     <= S_RESPAWN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESPAWN: begin
                    if (r_respawn_1 && bus.respawned_1) begin
                        r_respawn_1 <= 1'b0;
                        r_size_1    <= C_INIT_LEN;
                        r_dir_1     <= 2'd3;
                    end
                    if (r_respawn_2 && bus.respawned_2) begin
                        r_respawn_2 <= 1'b0;
                        r_size_2    <= C_INIT_LEN;
                        r_dir_2     <= 2'd1;
                    end
                    if (!w_pend_1 && !w_pend_2) begin
                        r_tick  <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.go_signal    = r_go;
    assign bus.dir_1        = r_dir_1;
    assign bus.dir_2        = r_dir_2;
    assign bus.snake_1_size = r_size_1;
    assign bus.snake_2_size = r_size_2;
    assign bus.seg_idx      = r_seg_idx;
    assign bus.respawn_1    = r_respawn_1;
    assign bus.respawn_2    = r_respawn_2;
    assign bus.food_eaten   = r_food;
    assign bus.dead         = r_dead;

endmodule

`default_nettype wire
